// File: rtl/fsm.sv
// Two-input sequence detector: in0 arms, in1 pairs, both together fire a
// HOLD-cycle pulse. Both inputs are asynchronous and pass through synchronizers.
`timescale 1ns/1ps
module fsm #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD        = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic in0,
    input  logic in1,
    output logic out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] PAIR = 2'd2;
    localparam logic [1:0] FIRE = 2'd3;

    // FIRE runs while the counter walks HOLD-1 down to 0, i.e. HOLD cycles.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

    logic [SYNC_STAGES-1:0] sync0;
    logic [SYNC_STAGES-1:0] sync1;
    logic                   s0;
    logic                   s1;
    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [7:0]             cnt;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= {sync0[SYNC_STAGES-2:0], in0};
            sync1 <= {sync1[SYNC_STAGES-2:0], in1};
        end
    end

    assign s0 = sync0[SYNC_STAGES-1];
    assign s1 = sync1[SYNC_STAGES-1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (s0) state_nxt = ARM;
            ARM: begin
                if (s1)       state_nxt = PAIR;
                else if (!s0) state_nxt = IDLE;
            end
            PAIR: begin
                if (s0 && s1) state_nxt = FIRE;
                else if (!s1) state_nxt = ARM;
            end
            FIRE: if (cnt == 8'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == PAIR && state_nxt == FIRE)
                cnt <= HOLD_LOAD;
            else if (state == FIRE && cnt != 8'd0)
                cnt <= cnt - 8'd1;
        end
    end

    // Pure state decode, so reset clears out without waiting for a clock.
    assign out = (state == FIRE);

endmodule

// File: tb/tb_fsm.sv
// Bench for fsm: three instances (default, HOLD=1, SYNC_STAGES=3) share stimulus
// and are compared every cycle against a rule-level reference model.
`timescale 1ns/1ps
module tb_fsm;

    localparam int SN[3] = '{2, 2, 3};
    localparam int HN[3] = '{4, 1, 4};

    logic clk;
    logic rst;
    logic in0;
    logic in1;
    logic [2:0] outs;
    logic [1:0] st [3];

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;

    fsm #(.SYNC_STAGES(2), .HOLD(4)) u_d0 (.clk(clk), .rstn(rst), .in0(in0), .in1(in1), .out(outs[0]));
    fsm #(.SYNC_STAGES(2), .HOLD(1)) u_d1 (.clk(clk), .rstn(rst), .in0(in0), .in1(in1), .out(outs[1]));
    fsm #(.SYNC_STAGES(3), .HOLD(4)) u_d2 (.clk(clk), .rstn(rst), .in0(in0), .in1(in1), .out(outs[2]));

    assign st[0] = u_d0.state;
    assign st[1] = u_d1.state;
    assign st[2] = u_d2.state;

    // Clock edges sit on half-ns points so integer-time input changes never collide.
    initial begin
        clk = 0;
        #0.5;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: phase 0..3 = idle/armed/paired/firing, left = FIRE cycles to go.
    bit hist0[$] = '{0, 0, 0, 0};
    bit hist1[$] = '{0, 0, 0, 0};
    int m_mode[3] = '{0, 0, 0};
    int m_left[3] = '{0, 0, 0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist0 = '{0, 0, 0, 0};
            hist1 = '{0, 0, 0, 0};
            for (int i = 0; i < 3; i++) begin
                m_mode[i] = 0;
                m_left[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit a, b;
                a = hist0[SN[i]-1];
                b = hist1[SN[i]-1];
                case (m_mode[i])
                    0: if (a) m_mode[i] = 1;
                    1: if (b) m_mode[i] = 2; else if (!a) m_mode[i] = 0;
                    2: begin
                        if (a && b) begin
                            m_mode[i] = 3;
                            m_left[i] = HN[i];
                        end else if (!b) m_mode[i] = 1;
                    end
                    default: begin
                        m_left[i] = m_left[i] - 1;
                        if (m_left[i] == 0) m_mode[i] = 0;
                    end
                endcase
            end
            hist0.push_front(in0);
            hist1.push_front(in1);
            void'(hist0.pop_back());
            void'(hist1.pop_back());
        end
    end

    int run[3] = '{0, 0, 0};
    logic [1:0] prev_st[3];

    always @(posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            run[i] = 0;
            prev_st[i] = 2'd0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic [1:0] exp_st;
                exp_st = 2'(m_mode[i]);
                chk($sformatf("out[%0d]", i), {7'd0, outs[i]}, {7'd0, (m_mode[i] == 3)});
                chk($sformatf("state[%0d]", i), {6'd0, st[i]}, {6'd0, exp_st});
                if (outs[i] === 1'b1) begin
                    run[i]++;
                    if (run[i] == 1) chk($sformatf("fire_after_pair[%0d]", i), {6'd0, prev_st[i]}, 8'd2);
                end else if (run[i] != 0) begin
                    chk($sformatf("run_len[%0d]", i), 8'(run[i]), 8'(HN[i]));
                    run[i] = 0;
                end
                prev_st[i] = st[i];
            end
        end
    end

    task automatic align;
        @(negedge clk);
        #0.2;
    endtask

    initial begin
        int lat0, lat2, fires;
        bit last_out;
        rst = 1;
        in0 = 0;
        in1 = 0;
        chk_en = 1;

        // Reset held for 100 ns while inputs wiggle.
        for (int k = 0; k < 14; k++) begin
            in0 = 1'($urandom_range(0, 1));
            in1 = 1'($urandom_range(0, 1));
            #7;
        end
        chk("rst_out", {7'd0, outs[0]}, 8'd0);
        chk("rst_state", {6'd0, st[0]}, 8'd0);
        in0 = 0;
        in1 = 0;
        #2;
        rst = 0;
        repeat (6) @(negedge clk);
        chk("idle_after_rst", {6'd0, st[0]}, 8'd0);

        // Detection latency: SYNC_STAGES+1 edges.
        align;
        in0 = 1;
        lat0 = 0;
        lat2 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (lat0 == 0 && st[0] != 2'd0) lat0 = k;
            if (lat2 == 0 && st[2] != 2'd0) lat2 = k;
        end
        chk("latency_s2", 8'(lat0), 8'd3);
        chk("latency_s3", 8'(lat2), 8'd4);

        // Abort from ARM back to IDLE.
        align;
        in0 = 0;
        repeat (5) @(negedge clk);
        chk("arm_abort", {6'd0, st[0]}, 8'd0);
        chk("arm_abort_out", {7'd0, outs[0]}, 8'd0);

        // PAIR abort: in1 falls, one step back to ARM.
        align;
        in0 = 1;
        repeat (4) @(negedge clk);
        #0.2;
        in0 = 0;
        in1 = 1;
        repeat (5) @(negedge clk);
        chk("pair_hold", {6'd0, st[0]}, 8'd2);
        #0.2;
        in1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("pair_abort", {6'd0, st[0]}, 8'd1);
        repeat (4) @(negedge clk);
        chk("pair_abort_idle", {6'd0, st[0]}, 8'd0);

        // Detection with both held: fires, re-arms, fires again.
        align;
        in0 = 1;
        repeat (3) @(negedge clk);
        #0.2;
        in1 = 1;
        fires = 0;
        last_out = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (outs[0] === 1'b1 && !last_out) fires++;
            last_out = outs[0];
        end
        chk("refire", 8'(fires >= 3), 8'd1);

        // Mid-FIRE reset during the second FIRE cycle.
        for (int k = 0; k < 40 && outs[0] !== 1'b1; k++) @(negedge clk);
        chk("fire_reached", {7'd0, outs[0]}, 8'd1);
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("async_drop", {7'd0, outs[0]}, 8'd0);
        #2;
        rst = 0;
        #0.5;
        chk("restart_idle", {6'd0, st[0]}, 8'd0);
        align;
        in0 = 0;
        in1 = 0;
        repeat (10) @(negedge clk);

        // Free-running stimulus: in0 every 13 ns, in1 every 17 ns, 50 us.
        align;
        for (int t = 0; t < 50000; t++) begin
            if (t % 13 == 0) in0 = ~in0;
            if (t % 17 == 0) in1 = ~in1;
            #1;
        end

        // Random levels and dwell times.
        repeat (400) begin
            in0 = 1'($urandom_range(0, 1));
            in1 = 1'($urandom_range(0, 1));
            #($urandom_range(1, 80));
        end

        in0 = 0;
        in1 = 0;
        repeat (12) @(negedge clk);
        chk("final_idle", {6'd0, st[0]}, 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
